// File: rtl/mips_isa_pkg.sv
// Shared MIPS ISA constants: opcode/funct maps, mnemonic codes and loader FSM states.
// Imported by the instruction encoder/loader and by the opcode control decoder.
package mips_isa_pkg;

  localparam logic [5:0] opR    = 6'h00;
  localparam logic [5:0] opJ    = 6'h02;
  localparam logic [5:0] opJal  = 6'h03;
  localparam logic [5:0] opBeq  = 6'h04;
  localparam logic [5:0] opBne  = 6'h05;
  localparam logic [5:0] opAddi = 6'h08;
  localparam logic [5:0] opAndi = 6'h0c;
  localparam logic [5:0] opOri  = 6'h0d;
  localparam logic [5:0] opLui  = 6'h0f;
  localparam logic [5:0] opLw   = 6'h23;
  localparam logic [5:0] opSw   = 6'h2b;

  localparam logic [5:0] functSll = 6'h00;
  localparam logic [5:0] functSrl = 6'h02;
  localparam logic [5:0] functJr  = 6'h08;
  localparam logic [5:0] functAdd = 6'h20;
  localparam logic [5:0] functSub = 6'h22;
  localparam logic [5:0] functAnd = 6'h24;
  localparam logic [5:0] functOr  = 6'h25;
  localparam logic [5:0] functNor = 6'h27;

  typedef enum logic [4:0] {
    mnAdd  = 5'd0,  mnSub  = 5'd1,  mnAnd  = 5'd2,  mnOr   = 5'd3,
    mnNor  = 5'd4,  mnSll  = 5'd5,  mnSrl  = 5'd6,  mnJr   = 5'd7,
    mnAddi = 5'd8,  mnOri  = 5'd9,  mnAndi = 5'd10, mnLui  = 5'd11,
    mnLw   = 5'd12, mnSw   = 5'd13, mnBeq  = 5'd14, mnBne  = 5'd15,
    mnJ    = 5'd16, mnJal  = 5'd17
  } mnemT;

  typedef enum logic [1:0] {
    stateIdle = 2'd0,
    stateLoad = 2'd1,
    stateDone = 2'd2
  } loaderStateT;

  function automatic logic [31:0] rType(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [4:0] shamt,
                                        input logic [5:0] funct);
    return {opR, rs, rt, rd, shamt, funct};
  endfunction

  function automatic logic [31:0] iType(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] jType(input logic [5:0] op, input logic [25:0] target);
    return {op, target};
  endfunction

endpackage

// File: rtl/instr_encoder_loader_pack.sv
// instr_pack: combinational packer from mnemonic plus fields to a 32-bit MIPS word.
// Illegal mnemonics produce a NOP (all zeros) and raise the illegal flag.
module instr_pack
  import mips_isa_pkg::*;
(
  input  logic [4:0]  mnem,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [4:0]  shamt,
  input  logic [15:0] imm,
  input  logic [25:0] target,
  output logic [31:0] word,
  output logic        illegal
);

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    word    = '0;
    illegal = 1'b0;
    case (mnem)
      mnAdd:  word = rType(rs, rt, rd, shamt, functAdd);
      mnSub:  word = rType(rs, rt, rd, shamt, functSub);
      mnAnd:  word = rType(rs, rt, rd, shamt, functAnd);
      mnOr:   word = rType(rs, rt, rd, shamt, functOr);
      mnNor:  word = rType(rs, rt, rd, shamt, functNor);
      mnSll:  word = rType(rs, rt, rd, shamt, functSll);
      mnSrl:  word = rType(rs, rt, rd, shamt, functSrl);
      mnJr:   word = rType(rs, rt, rd, shamt, functJr);
      mnAddi: word = iType(opAddi, rs, rt, imm);
      mnOri:  word = iType(opOri, rs, rt, imm);
      mnAndi: word = iType(opAndi, rs, rt, imm);
      mnLui:  word = iType(opLui, 5'd0, rt, imm);
      mnLw:   word = iType(opLw, rs, rt, imm);
      mnSw:   word = iType(opSw, rs, rt, imm);
      mnBeq:  word = iType(opBeq, rs, rt, imm);
      mnBne:  word = iType(opBne, rs, rt, imm);
      mnJ:    word = jType(opJ, target);
      mnJal:  word = jType(opJal, target);
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_encoder_loader.sv
// Streams symbolic instructions into instruction memory as packed MIPS words.
// Optional running XOR checksum of written words is enabled by LOADER_CHECKSUM_EN.
module instr_encoder_loader
  import mips_isa_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_last,
  input  logic [4:0]        mnem,
  input  logic [4:0]        rs,
  input  logic [4:0]        rt,
  input  logic [4:0]        rd,
  input  logic [4:0]        shamt,
  input  logic [15:0]       imm,
  input  logic [25:0]       target,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [ADDR_W:0]   word_count,
  output logic              done,
  output logic              illegal,
  output logic              full_err,
  output logic [31:0]       checksum
);

  localparam logic [ADDR_W:0] depthCount = (ADDR_W+1)'(DEPTH);

  loaderStateT     state, nextState;
  logic            accept;
  logic            sessionFull;
  logic [ADDR_W:0] countInc;
  logic [31:0]     packWord;
  logic            packIllegal;

  instr_pack u_pack (
    .mnem    (mnem),
    .rs      (rs),
    .rt      (rt),
    .rd      (rd),
    .shamt   (shamt),
    .imm     (imm),
    .target  (target),
    .word    (packWord),
    .illegal (packIllegal)
  );

  assign in_ready    = (state == stateLoad);
  assign done        = (state == stateDone);
  // start wins over a same-cycle accept; that instruction is dropped.
  assign accept      = in_valid & in_ready & ~start;
  assign countInc    = word_count + 1'b1;
  assign sessionFull = (countInc == depthCount);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) state <= stateIdle;
    else       state <= nextState;
  end

  always_comb begin
    nextState = state;
    if (start)
      nextState = stateLoad;
    else if (accept && (in_last || sessionFull))
      nextState = stateDone;
  end

  // The write pointer is the low bits of word_count; both advance together.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      word_count <= '0;
      illegal    <= 1'b0;
      full_err   <= 1'b0;
    end else begin
      mem_we <= accept;
      if (start) begin
        word_count <= '0;
        illegal    <= 1'b0;
        full_err   <= 1'b0;
      end else if (accept) begin
        mem_addr   <= word_count[ADDR_W-1:0];
        mem_wdata  <= packWord;
        word_count <= countInc;
        if (packIllegal)            illegal  <= 1'b1;
        if (sessionFull && !in_last) full_err <= 1'b1;
      end
    end
  end

`ifdef LOADER_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (reset || start) checksum <= '0;
    else if (mem_we)    checksum <= checksum ^ mem_wdata;
  end
`else
  assign checksum = '0;
`endif

endmodule

// File: doc/instr_encoder_loader.md
Name: instr_encoder_loader

Overview:
Encoder counterpart of the opcode control decoder. Accepts symbolic instructions (mnemonic plus fields) over a valid/ready stream. Packs each one into a 32-bit MIPS word using the same opcode/funct map, and writes the words sequentially into instruction memory. Used by the bench/boot path to load programs into the unicycle core's ROM/RAM.

Parameters:
ADDR_W, 8, width of word address to instruction memory
DEPTH, 256, max words per load session (must be <= 2**ADDR_W)

Ports:
clk  in  1  single clock, rising edge
reset  in  1  synchronous, active-high reset
start  in  1  one-cycle pulse: begin/restart a load session at word address 0
in_valid  in  1  instruction fields valid
in_ready  out  1  encoder can accept this cycle
in_last  in  1  marks final instruction of the program
mnem  in  5  mnemonic code: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 NOR, 5 SLL, 6 SRL, 7 JR, 8 ADDI, 9 ORI, 10 ANDI, 11 LUI, 12 LW, 13 SW, 14 BEQ, 15 BNE, 16 J, 17 JAL; 18-31 illegal
rs, rt, rd, shamt  in  5 each  register/shift fields
imm  in  16  immediate / branch offset
target  in  26  jump target field
mem_we  out  1  write strobe to instruction memory
mem_addr  out  ADDR_W  word address
mem_wdata  out  32  encoded instruction
word_count  out  ADDR_W+1  words written this session
done  out  1  session complete (level)
illegal  out  1  sticky: illegal mnemonic seen this session
full_err  out  1  sticky: DEPTH reached without in_last
checksum  out  32  XOR of all written words (see Optional Feature)

Behaviour:
- Reset: state IDLE; all outputs 0 (in_ready, mem_we, mem_addr, mem_wdata, word_count, done, illegal, full_err, checksum).
- States:
  - IDLE: in_ready=0; start -> LOAD.
  - LOAD: in_ready=1.
  - DONE: in_ready=0, done=1; start -> LOAD.
- Accept = in_valid & in_ready.
- Encoding rules:
  - R-type: op=0x00 | rs | rt | rd | shamt | funct. Funct: ADD 0x20, SUB 0x22, AND 0x24, OR 0x25, NOR 0x27, SLL 0x00, SRL 0x02, JR 0x08.
  - I-type: op | rs | rt | imm. Op: ADDI 0x08, ORI 0x0d, ANDI 0x0c, LUI 0x0f (rs forced 0), LW 0x23, SW 0x2b, BEQ 0x04, BNE 0x05.
  - J-type: op | target. Op: J 0x02, JAL 0x03.
  - Bit placement: op[31:26], rs[25:21], rt[20:16], rd[15:11], shamt[10:6], funct/imm low bits.
- Latency: 1 cycle. An accept in cycle N gives mem_we=1 in cycle N+1, with mem_addr = current write pointer and mem_wdata = encoded word. mem_we is otherwise 0. mem_addr and mem_wdata hold their last values.
- Pointer and word_count increment on each accept.
- Illegal mnemonic: the word is written as 0x00000000 (NOP), illegal is set, and the session continues.
- Accept with in_last: LOAD -> DONE on that edge, so done rises in the same cycle as the final mem_we.
- Accept that makes word_count == DEPTH without in_last: -> DONE, full_err set. in_last on the DEPTH-th word is not an error.
- start in any state (including LOAD mid-session): pointer, word_count, illegal, full_err, checksum cleared; -> LOAD. A pending registered write still completes in the following cycle. start takes priority over a same-cycle accept, which is dropped.
- start in DONE restarts a new session.
- reset mid-session aborts immediately; no pending write is emitted.

Optional Feature:
- Macro LOADER_CHECKSUM_EN.
- Defined: checksum updates on each mem_we cycle with checksum ^= mem_wdata, visible the cycle after that write. Cleared by reset and start.
- Undefined: checksum is tied to 0; no XOR logic.

Decomposition:
- Shared package mips_isa_pkg:
  - opcode localparams (R, ADDI, ORI, ANDI, LUI, LW, SW, BEQ, BNE, J, JAL);
  - funct localparams;
  - mnemonic enum codes;
  - FSM state encoding (IDLE, LOAD, DONE).
- The control decoder should import the same opcode constants.
- One natural sub-module: instr_pack, purely combinational (mnem plus fields -> 32-bit word and illegal flag). The loader wraps it with the FSM, pointer, and output register.

Test Plan:
- reset, start, one accept of ADD rs=1 rt=2 rd=3 with in_last -> next cycle mem_we=1, addr 0, wdata 0x00221820; done=1; word_count=1.
- Stream of three with in_valid held, in_last on the third: ADDI rt=8 rs=0 imm=5; LW rt=9 rs=29 imm=4; J target=0x0100000 -> wdata 0x20080005, 0x8FA90004, 0x08100000 at addr 0, 1, 2 on consecutive cycles.
- BEQ rs=1 rt=2 imm=0xFFFF, then mnem=25 -> writes 0x1022FFFF, then 0x00000000; illegal=1 (sticky until start).
- DEPTH=4, five valid words with no in_last -> four writes; full_err=1; done=1; in_ready=0; fifth word not accepted.
- start pulse mid-session after 2 words -> next accept writes addr 0; word_count, flags, and checksum restart.
- LOADER_CHECKSUM_EN defined: write 0x00221820 then 0x20080005 -> checksum 0x202A1825; undefined -> checksum stays 0.
